// File: rtl/alu_exec_unit.sv
// ============================================================================
// Module      : alu_exec_unit
// Description : Execute-stage ALU. Consumes a 5-bit ALU control code, two
//               operands and a destination tag; returns a registered result
//               over valid/ready handshakes. Non-shift ops take one cycle.
//               Shifts iterate one bit per cycle unless BARREL_SHIFT_EN is
//               defined, in which case a single-cycle barrel shifter is used
//               and the SHIFT state and counter are absent.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_ctrl,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic             out_zero,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam int c_shw = $clog2(XLEN);

    localparam logic [4:0] c_op_and   = 5'b00000;
    localparam logic [4:0] c_op_or    = 5'b00001;
    localparam logic [4:0] c_op_add   = 5'b00010;
    localparam logic [4:0] c_op_sll   = 5'b00011;
    localparam logic [4:0] c_op_sltu  = 5'b00100;
    localparam logic [4:0] c_op_xor   = 5'b00101;
    localparam logic [4:0] c_op_sub   = 5'b00110;
    localparam logic [4:0] c_op_srl   = 5'b00111;
    localparam logic [4:0] c_op_slt   = 5'b01000;
    localparam logic [4:0] c_op_sra   = 5'b01001;
    localparam logic [4:0] c_op_passb = 5'b01010;

    logic [c_shw-1:0] w_shamt;
    logic [XLEN-1:0]  w_result;
    logic             w_illegal;
    logic             w_accept;

    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_result;
    logic             r_out_zero;
    logic             r_out_illegal;
    logic [TAG_W-1:0] r_out_tag;

    assign w_shamt  = in_b[c_shw-1:0];
    assign w_accept = in_valid && in_ready;

    assign out_valid   = r_out_valid;
    assign out_result  = r_out_result;
    assign out_zero    = r_out_zero;
    assign out_illegal = r_out_illegal;
    assign out_tag     = r_out_tag;

`ifdef BARREL_SHIFT_EN

    // Single-cycle datapath: every code, shifts included, resolves here.
    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        case (in_ctrl)
            c_op_and:   w_result = in_a & in_b;
            c_op_or:    w_result = in_a | in_b;
            c_op_add:   w_result = in_a + in_b;
            c_op_sll:   w_result = in_a << w_shamt;
            c_op_sltu:  w_result = {{(XLEN-1){1'b0}}, (in_a < in_b)};
            c_op_xor:   w_result = in_a ^ in_b;
            c_op_sub:   w_result = in_a + ~in_b + 1'b1;
            c_op_srl:   w_result = in_a >> w_shamt;
            c_op_slt:   w_result = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            c_op_sra:   w_result = $unsigned($signed(in_a) >>> w_shamt);
            c_op_passb: w_result = in_b;
            default:    w_illegal = 1'b1;
        endcase
    end

    assign in_ready = (!r_out_valid || out_ready) && !flush;

    // Output register: written on accept, cleared when consumed, killed by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_zero    <= 1'b0;
            r_out_illegal <= 1'b0;
            r_out_tag     <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else begin
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_out_valid   <= 1'b1;
                r_out_result  <= w_result;
                r_out_zero    <= (w_result == '0);
                r_out_illegal <= w_illegal;
                r_out_tag     <= in_tag;
            end
        end
    end

`else

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_shift = 1'b1;

    localparam logic [1:0] c_dir_sll = 2'd0;
    localparam logic [1:0] c_dir_srl = 2'd1;
    localparam logic [1:0] c_dir_sra = 2'd2;

    localparam logic [c_shw-1:0] c_cnt_one = c_shw'(1);

    logic [0:0]       r_state;
    logic [XLEN-1:0]  r_acc;
    logic [c_shw-1:0] r_cnt;
    logic [1:0]       r_dir;
    logic [TAG_W-1:0] r_tag;
    logic [XLEN-1:0]  w_acc_next;
    logic [1:0]       w_dir;
    logic             w_is_shift;
    logic             w_start_shift;

    // Single-cycle datapath; shift codes yield in_a, which is the shamt==0 answer.
    always_comb begin
        w_result   = '0;
        w_illegal  = 1'b0;
        w_is_shift = 1'b0;
        w_dir      = c_dir_sll;
        case (in_ctrl)
            c_op_and:   w_result = in_a & in_b;
            c_op_or:    w_result = in_a | in_b;
            c_op_add:   w_result = in_a + in_b;
            c_op_sll:   begin w_result = in_a; w_is_shift = 1'b1; w_dir = c_dir_sll; end
            c_op_sltu:  w_result = {{(XLEN-1){1'b0}}, (in_a < in_b)};
            c_op_xor:   w_result = in_a ^ in_b;
            c_op_sub:   w_result = in_a + ~in_b + 1'b1;
            c_op_srl:   begin w_result = in_a; w_is_shift = 1'b1; w_dir = c_dir_srl; end
            c_op_slt:   w_result = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            c_op_sra:   begin w_result = in_a; w_is_shift = 1'b1; w_dir = c_dir_sra; end
            c_op_passb: w_result = in_b;
            default:    w_illegal = 1'b1;
        endcase
    end

    // One-bit step of the iterative shifter in the latched direction.
    always_comb begin
        case (r_dir)
            c_dir_sll: w_acc_next = {r_acc[XLEN-2:0], 1'b0};
            c_dir_srl: w_acc_next = {1'b0, r_acc[XLEN-1:1]};
            default:   w_acc_next = {r_acc[XLEN-1], r_acc[XLEN-1:1]};
        endcase
    end

    assign w_start_shift = w_is_shift && (w_shamt != '0);
    assign in_ready      = (r_state == c_st_idle) && (!r_out_valid || out_ready) && !flush;

    // Control FSM with registered outputs; flush outranks everything but reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_st_idle;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_dir         <= c_dir_sll;
            r_tag         <= '0;
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_zero    <= 1'b0;
            r_out_illegal <= 1'b0;
            r_out_tag     <= '0;
        end else if (flush) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // Consumed results drop; a new write below on the same edge wins.
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        if (w_start_shift) begin
                            r_acc   <= in_a;
                            r_cnt   <= w_shamt;
                            r_dir   <= w_dir;
                            r_tag   <= in_tag;
                            r_state <= c_st_shift;
                        end else begin
                            r_out_valid   <= 1'b1;
                            r_out_result  <= w_result;
                            r_out_zero    <= (w_result == '0);
                            r_out_illegal <= w_illegal;
                            r_out_tag     <= in_tag;
                        end
                    end
                end
                c_st_shift: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_out_valid   <= 1'b1;
                        r_out_result  <= w_acc_next;
                        r_out_zero    <= (w_acc_next == '0);
                        r_out_illegal <= 1'b0;
                        r_out_tag     <= r_tag;
                        r_state       <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Self-checking bench for alu_exec_unit. A behavioural model
//               (plain arithmetic plus a latency countdown) is compared to
//               the DUT on every negedge; directed vectors add literal checks.
//               Honours BARREL_SHIFT_EN for expected shift latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_ctrl;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_illegal;
    logic [4:0]  out_tag;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_illegal(out_illegal),
        .out_tag    (out_tag)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU: {illegal, result}
    function automatic logic [32:0] ref_alu(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic [31:0] r;
        logic ill;
        sa  = a;
        r   = 32'h0;
        ill = 1'b0;
        case (c)
            5'd0:  r = a & b;
            5'd1:  r = a | b;
            5'd2:  r = a + b;
            5'd3:  r = a << b[4:0];
            5'd4:  r = (a < b) ? 32'd1 : 32'd0;
            5'd5:  r = a ^ b;
            5'd6:  r = a - b;
            5'd7:  r = a >> b[4:0];
            5'd8:  r = (sa < $signed(b)) ? 32'd1 : 32'd0;
            5'd9:  r = sa >>> b[4:0];
            5'd10: r = b;
            default: ill = 1'b1;
        endcase
        return {ill, r};
    endfunction

    function automatic int ref_lat(input logic [4:0] c, input logic [31:0] b);
`ifdef BARREL_SHIFT_EN
        return 1;
`else
        if (c == 5'd3 || c == 5'd7 || c == 5'd9) return 1 + int'(b[4:0]);
        return 1;
`endif
    endfunction

    // Model state
    logic        m_valid;
    logic [31:0] m_result;
    logic        m_zero;
    logic        m_ill;
    logic [4:0]  m_tag;
    int          m_busy;
    logic [31:0] p_result;
    logic        p_ill;
    logic [4:0]  p_tag;
    logic        m_rdy;
    logic [32:0] m_r;
    int          m_l;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_result = 32'h0; m_zero = 1'b0; m_ill = 1'b0; m_tag = 5'h0;
            m_busy = 0;
        end else begin
            m_rdy = (m_busy == 0) && (!m_valid || out_ready) && !flush;
            if (flush) begin
                m_valid = 1'b0;
                m_busy  = 0;
            end else begin
                if (m_valid && out_ready) m_valid = 1'b0;
                if (m_busy > 0) begin
                    m_busy--;
                    if (m_busy == 0) begin
                        m_valid = 1'b1; m_result = p_result; m_zero = (p_result == 32'h0);
                        m_ill = p_ill; m_tag = p_tag;
                    end
                end else if (in_valid && m_rdy) begin
                    m_r = ref_alu(in_ctrl, in_a, in_b);
                    m_l = ref_lat(in_ctrl, in_b);
                    p_result = m_r[31:0]; p_ill = m_r[32]; p_tag = in_tag;
                    if (m_l == 1) begin
                        m_valid = 1'b1; m_result = p_result; m_zero = (p_result == 32'h0);
                        m_ill = p_ill; m_tag = p_tag;
                    end else begin
                        m_busy = m_l - 1;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle compare against the model
    always @(negedge clk) begin
        if (rst_n) begin
            check("model_in_ready", {31'h0, in_ready}, {31'h0, (m_busy == 0) && (!m_valid || out_ready) && !flush});
            check("model_out_valid", {31'h0, out_valid}, {31'h0, m_valid});
            if (m_valid) begin
                check("model_result", out_result, m_result);
                check("model_zero", {31'h0, out_zero}, {31'h0, m_zero});
                check("model_illegal", {31'h0, out_illegal}, {31'h0, m_ill});
                check("model_tag", {27'h0, out_tag}, {27'h0, m_tag});
            end
        end
    end

    // Starts and ends at posedge+1
    task automatic issue(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        in_ctrl = c; in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            waited++;
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL issue_timeout: in_ready never high, ctrl %0d", c);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Starts at posedge+1, samples result at the negedge where out_valid rises, ends at posedge+1
    task automatic wait_out(output int lat, output logic [31:0] res, output logic zero,
                            output logic ill, output logic [4:0] tag);
        bit ok;
        ok = 1'b0;
        lat = 0; res = 32'h0; zero = 1'b0; ill = 1'b0; tag = 5'h0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL wait_out_timeout: out_valid never rose");
        end
        res = out_result; zero = out_zero; ill = out_illegal; tag = out_tag;
        @(posedge clk); #1;
    endtask

    task automatic run_op(input string name, input logic [4:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] t,
                          input int exp_lat, input logic [31:0] exp_res, input logic exp_ill);
        int w, lat;
        logic [31:0] res;
        logic z, il;
        logic [4:0] tg;
        issue(c, a, b, t, w);
        wait_out(lat, res, z, il, tg);
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_result"}, res, exp_res);
        check({name, "_zero"}, {31'h0, z}, {31'h0, exp_res == 32'h0});
        check({name, "_illegal"}, {31'h0, il}, {31'h0, exp_ill});
        check({name, "_tag"}, {27'h0, tg}, {27'h0, t});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, lat, sra_lat, srl_lat;
        logic [31:0] res;
        logic z, il;
        logic [4:0] tg;
`ifdef BARREL_SHIFT_EN
        sra_lat = 1; srl_lat = 1;
`else
        sra_lat = 5; srl_lat = 32;
`endif
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = 5'h0;
        in_a = 32'h0; in_b = 32'h0; in_tag = 5'h0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", {31'h0, out_valid}, 32'h0);
        check("reset_result", out_result, 32'h0);
        check("reset_zero", {31'h0, out_zero}, 32'h0);
        check("reset_illegal", {31'h0, out_illegal}, 32'h0);
        check("reset_tag", {27'h0, out_tag}, 32'h0);
        rst_n = 1'b1;

        // Basic one-cycle ops
        run_op("add", 5'd2, 32'h7FFF_FFFF, 32'h1, 5'd1, 1, 32'h8000_0000, 1'b0);
        run_op("sub", 5'd6, 32'd5, 32'd5, 5'd2, 1, 32'h0, 1'b0);
        run_op("slt", 5'd8, 32'hFFFF_FFFF, 32'h1, 5'd3, 1, 32'h1, 1'b0);
        run_op("sltu", 5'd4, 32'hFFFF_FFFF, 32'h1, 5'd4, 1, 32'h0, 1'b0);
        run_op("passb", 5'd10, 32'hDEAD_BEEF, 32'h1234_5000, 5'd5, 1, 32'h1234_5000, 1'b0);
        run_op("xor", 5'd5, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd6, 1, 32'hFF00_EDCB, 1'b0);

        // Shifts
        run_op("sra4", 5'd9, 32'h8000_0000, 32'd4, 5'd7, sra_lat, 32'hF800_0000, 1'b0);
        run_op("srl31", 5'd7, 32'h8000_0000, 32'd31, 5'd8, srl_lat, 32'h1, 1'b0);
        run_op("sll0", 5'd3, 32'h0000_ABCD, 32'hFFFF_FFE0, 5'd9, 1, 32'h0000_ABCD, 1'b0);

        // Backpressure: result held, in_ready low, then release with a new op same cycle
        out_ready = 1'b0;
        issue(5'd2, 32'd3, 32'd4, 5'd10, w);
        wait_out(lat, res, z, il, tg);
        check("bp_lat", 32'(lat), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_valid", {31'h0, out_valid}, 32'h1);
            check("bp_result", out_result, 32'd7);
            check("bp_tag", {27'h0, out_tag}, 32'd10);
            check("bp_in_ready", {31'h0, in_ready}, 32'h0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(5'd1, 32'h0000_0F00, 32'h0000_00F0, 5'd11, w);
        check("bp_release_wait", 32'(w), 32'd1);
        wait_out(lat, res, z, il, tg);
        check("bp_release_result", res, 32'h0000_0FF0);
        check("bp_release_tag", {27'h0, tg}, 32'd11);

        // Flush mid-shift
        issue(5'd3, 32'h1, 32'd20, 5'd12, w);
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready_low", {31'h0, in_ready}, 32'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_valid", {31'h0, out_valid}, 32'h0);
        check("flush_in_ready", {31'h0, in_ready}, 32'h1);
        repeat (25) @(posedge clk);
        #1;

        // Async reset mid-shift
        run_op("or", 5'd1, 32'h0000_00F0, 32'h0, 5'd9, 1, 32'h0000_00F0, 1'b0);
        issue(5'd3, 32'h1, 32'd20, 5'd13, w);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'h0, out_valid}, 32'h0);
        check("arst_result", out_result, 32'h0);
        check("arst_zero", {31'h0, out_zero}, 32'h0);
        check("arst_illegal", {31'h0, out_illegal}, 32'h0);
        check("arst_tag", {27'h0, out_tag}, 32'h0);
        check("arst_in_ready", {31'h0, in_ready}, 32'h1);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Illegal codes
        run_op("ill31", 5'd31, 32'd5, 32'd6, 5'd14, 1, 32'h0, 1'b1);
        run_op("ill11", 5'd11, 32'hFFFF_FFFF, 32'h1, 5'd15, 1, 32'h0, 1'b1);

        // Back-to-back ANDs, one result per cycle, tags in order
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_ctrl = 5'd0;
            in_a = 32'h0000_F0F0 | 32'(i); in_b = 32'h0000_00FF; in_tag = 5'(16 + i);
            @(negedge clk);
            check("b2b_in_ready", {31'h0, in_ready}, 32'h1);
            if (i > 0) begin
                check("b2b_valid", {31'h0, out_valid}, 32'h1);
                check("b2b_tag", {27'h0, out_tag}, 32'(16 + i - 1));
                check("b2b_result", out_result, 32'h0000_00F0 | 32'(i - 1));
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_last_valid", {31'h0, out_valid}, 32'h1);
        check("b2b_last_tag", {27'h0, out_tag}, 32'd19);
        check("b2b_last_result", out_result, 32'h0000_00F3);
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 5-bit ALU control code produced by the decode-side ALU control block, plus two operands and a destination tag.
- Returns a registered result toward the EX/MEM boundary over valid/ready handshakes.
- Non-shift ops complete in 1 cycle; shifts iterate one bit per cycle to save area, so the unit can backpressure the pipeline.

Parameters:
- XLEN, 32, operand/result width; shift amount width is $clog2(XLEN) taken from in_b LSBs.
- TAG_W, 5, width of the destination register tag passed through.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous kill of in-flight op and pending output
- in_valid  input  1  operation offered
- in_ready  output  1  unit can accept this cycle
- in_ctrl  input  5  ALU control code
- in_a  input  XLEN  operand A (rs1)
- in_b  input  XLEN  operand B (rs2 or immediate)
- in_tag  input  TAG_W  destination tag
- out_valid  output  1  result held in output register
- out_ready  input  1  downstream consumes result
- out_result  output  XLEN  result
- out_zero  output  1  out_result == 0, for branch resolution
- out_illegal  output  1  in_ctrl was not a defined code
- out_tag  output  TAG_W  tag of the result

Behaviour:
- Codes:
  - 00000 AND; 00001 OR; 00010 ADD; 00011 SLL; 00100 SLTU; 00101 XOR; 00110 SUB; 00111 SRL; 01000 SLT; 01001 SRA; 01010 PASS-B (LUI).
  - Any other code (incl. 11111) gives result 0 and illegal=1, with latency 1.
- Arithmetic:
  - Wraps modulo 2^XLEN; SUB = a + ~b + 1.
  - SLT is signed; SLTU is unsigned; both give 1 or 0, zero-extended.
  - SRA replicates the sign bit.
- States: IDLE, SHIFT.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Accept = in_valid && in_ready.
- Non-shift accept: out_result/zero/illegal/tag registered on the accept edge; out_valid=1 next cycle (latency 1).
- Shift accept with shamt=0: same as non-shift, result = in_a.
- Shift accept with shamt=n>0:
  - On the accept edge: load acc=in_a, cnt=n, latch op and tag; go to SHIFT.
  - Each SHIFT edge shifts acc by 1 in the op direction and decrements cnt.
  - On the edge where cnt==1: write the shifted value to the output, set out_valid, return to IDLE.
  - Latency is 1+n cycles; in_ready=0 throughout.
- Output register:
  - Holds its value while out_valid && !out_ready.
  - out_valid clears on the edge where out_ready=1, unless a new result is written on that same edge. Back-to-back accepts give one result per cycle.
- Flush (sync, highest priority): next edge state=IDLE, out_valid=0, cnt=0; no accept that cycle; out_result contents don't-care.
- Reset (async, any state, incl. mid-shift): state=IDLE, out_valid=0, out_result=0, out_zero=0, out_illegal=0, out_tag=0, acc=0, cnt=0. The first accept is possible on the first edge after deassertion.
- Simultaneous out_ready and accept: the old result is consumed and the new one written on the same edge.

Optional Feature:
- BARREL_SHIFT_EN defined: SLL/SRL/SRA use a single-cycle barrel shifter; latency 1 for all codes; SHIFT state and counter are absent.
- BARREL_SHIFT_EN undefined: iterative shifter as specified above.

Test Plan:
- ADD a=0x7FFFFFFF, b=1, out_ready=1 → next cycle out_valid=1, result 0x80000000, zero=0; SUB a=5, b=5 → result 0, zero=1.
- SLT a=0xFFFFFFFF, b=1 → 1; SLTU with same operands → 0; PASS-B b=0x12345000 → 0x12345000.
- SRA a=0x80000000, b=4 (iterative build) → in_ready low 4 cycles, out_valid 5 cycles after accept, result 0xF8000000; with BARREL_SHIFT_EN → 1 cycle.
- Backpressure: hold out_ready=0 after an ADD result → result and tag stable and in_ready=0; release → next op accepted the same cycle.
- flush during SLL with b=20, mid-shift → next cycle IDLE, out_valid=0, in_ready=1; async rst_n pulse mid-shift → all outputs 0 immediately.
- in_ctrl=11111 → out_illegal=1, result 0, latency 1; back-to-back ANDs with out_ready=1 → one result per cycle, tags in order.
